// File: rtl/hazard_sequencer.sv
// Hazard/sequencing controller for the five-stage RV32I pipeline: reset flush,
// data forwarding, load-use and branch handling, memory-wait freeze and perf counters.
module hazard_sequencer #(
  parameter int RESET_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT        = 16,
  parameter int CNT_W              = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1D,
  input  logic [4:0]       RS2D,
  input  logic [4:0]       RS1E,
  input  logic [4:0]       RS2E,
  input  logic [4:0]       RDE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RDM,
  input  logic [4:0]       RDW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemAccessM,
  input  logic             DmemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int INIT_W = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT} state_t;

  state_t             state_q;
  logic [INIT_W-1:0]  init_q;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               mem_err_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic running, freeze, load_use, branch_flush;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm,
                                         input logic [4:0] rdm, input logic ww,
                                         input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                     return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(RS1E, RegWriteM, RDM, RegWriteW, RDW);
  assign ForwardBE = fwd_sel(RS2E, RegWriteM, RDM, RegWriteW, RDW);

  assign running      = (state_q != S_INIT);
  assign freeze       = running && MemAccessM && !DmemReadyM;
  assign load_use     = ResultSrcE && (RDE != 5'd0) && ((RDE == RS1D) || (RDE == RS2D));
  assign branch_flush = running && !freeze && PCSrcE;

  // Freeze outranks branch, branch outranks load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!running) begin
      StallF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (running && StallF && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (branch_flush && flush_cnt_q != '1)      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Wait counter saturates at the timeout so a hung access cannot wrap it.
  always_comb begin
    wait_d = '0;
    if (state_q == S_MEM_WAIT && freeze)
      wait_d = (wait_q == WAIT_W'(MEM_TIMEOUT)) ? wait_q : wait_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_q      <= '0;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_q      <= wait_d;
      case (state_q)
        S_INIT: begin
          if (init_q == INIT_W'(RESET_FLUSH_CYCLES - 1)) state_q <= S_RUN;
          else                                            init_q  <= init_q + 1'b1;
        end
        S_RUN: begin
          if (freeze) state_q <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          if (!freeze) state_q <= S_RUN;
          if (wait_d == WAIT_W'(MEM_TIMEOUT)) mem_err_q <= 1'b1;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign MemErr   = mem_err_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: vector table, hand-written multi-cycle sequences and
// randomized traffic against a cycle-level reference model; a 4-bit counter copy checks saturation.
module tb_hazard_sequencer;
  localparam int RFC = 2;
  localparam int MT  = 16;
  localparam int CW  = 32;
  localparam int CWS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
  logic ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemAccessM, DmemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCnt, FlushCnt;
  logic s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_MemErr;
  logic [1:0] s_ForwardAE, s_ForwardBE;
  logic [CWS-1:0] s_StallCnt, s_FlushCnt;

  hazard_sequencer #(.RESET_FLUSH_CYCLES(RFC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RDM(RDM), .RDW(RDW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemAccessM(MemAccessM),
    .DmemReadyM(DmemReadyM), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt));

  hazard_sequencer #(.RESET_FLUSH_CYCLES(RFC), .MEM_TIMEOUT(MT), .CNT_W(CWS)) dut_s (
    .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RDM(RDM), .RDW(RDW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemAccessM(MemAccessM),
    .DmemReadyM(DmemReadyM), .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE),
    .StallM(s_StallM), .FlushD(s_FlushD), .FlushE(s_FlushE), .ForwardAE(s_ForwardAE),
    .ForwardBE(s_ForwardBE), .MemErr(s_MemErr), .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt));

  always #5 clk = ~clk;

  // Control vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE}
  localparam logic [9:0] C_IDLE   = 10'b0000000000;
  localparam logic [9:0] C_INIT   = 10'b1000110000;
  localparam logic [9:0] C_FREEZE = 10'b1111000000;
  localparam logic [9:0] C_BRANCH = 10'b0000110000;
  localparam logic [9:0] C_LDUSE  = 10'b1100010000;

  int checks = 0;
  int errors = 0;

  // Reference model state: flush cycles left, waiting flag, wait length, sticky error, event counts.
  int m_init, m_wn, m_sc, m_fc;
  bit m_wait, m_err;

  logic [9:0]    last_ctl;
  logic [CW-1:0] last_sc, last_fc;
  logic [CWS-1:0] last_ssc;
  logic          last_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWriteM && RDM != 0 && RDM == rs) return 2'b10;
    if (RegWriteW && RDW != 0 && RDW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] m_ctl();
    logic [5:0] sf;
    bit frz, lu;
    frz = MemAccessM && !DmemReadyM;
    lu  = ResultSrcE && RDE != 0 && (RDE == RS1D || RDE == RS2D);
    if (m_init > 0)  sf = 6'b100011;
    else if (frz)    sf = 6'b111100;
    else if (PCSrcE) sf = 6'b000011;
    else if (lu)     sf = 6'b110001;
    else             sf = 6'b000000;
    return {sf, m_fwd(RS1E), m_fwd(RS2E)};
  endfunction

  function automatic int sat_s(input int n);
    return (n > (1 << CWS) - 1) ? (1 << CWS) - 1 : n;
  endfunction

  task automatic set_idle();
    {RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW} = '0;
    {ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemAccessM, DmemReadyM} = '0;
  endtask

  // One clock: sample on the falling edge, compare with the model, then advance the model.
  task automatic step(input string tag);
    logic [9:0] e;
    bit frz;
    @(negedge clk);
    e = m_ctl();
    last_ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE};
    last_sc = StallCnt; last_fc = FlushCnt; last_ssc = s_StallCnt; last_err = MemErr;
    chk({tag, ".ctl"}, last_ctl, e);
    chk({tag, ".memerr"}, MemErr, m_err);
    chk({tag, ".stallcnt"}, StallCnt, m_sc);
    chk({tag, ".flushcnt"}, FlushCnt, m_fc);
    chk({tag, ".stallcnt4"}, s_StallCnt, sat_s(m_sc));
    chk({tag, ".flushcnt4"}, s_FlushCnt, sat_s(m_fc));
    frz = MemAccessM && !DmemReadyM;
    if (m_init > 0) begin
      m_init--;
    end else begin
      if (e[9]) m_sc++;
      if (!frz && PCSrcE) m_fc++;
      if (m_wait && frz) begin
        if (m_wn < MT) m_wn++;
        if (m_wn == MT) m_err = 1;
      end else begin
        m_wn = 0;
      end
      m_wait = frz;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    m_init = RFC; m_wait = 0; m_wn = 0; m_err = 0; m_sc = 0; m_fc = 0;
    #2;
    chk({tag, ".rst_ctl"}, {StallF, StallD, StallE, StallM, FlushD, FlushE}, 6'b100011);
    chk({tag, ".rst_cnt"}, {MemErr, StallCnt, FlushCnt}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       lde, pcs, rwm, rww;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    //           rs1d rs2d rs1e rs2e rde rdm rdw lde pcs rwm rww exp
    vecs[0] = '{0,  0,  5,  0,  0,  5,  5, 0, 0, 1, 1, 10'b0000001000};
    vecs[1] = '{0,  0,  5,  0,  0,  5,  5, 0, 0, 0, 1, 10'b0000000100};
    vecs[2] = '{0,  0,  0,  0,  0,  0,  0, 0, 0, 1, 1, 10'b0000000000};
    vecs[3] = '{0,  0,  3,  9,  0,  9,  3, 0, 0, 1, 1, 10'b0000000110};
    vecs[4] = '{1,  7,  0,  0,  7,  0,  0, 1, 0, 0, 0, C_LDUSE};
    vecs[5] = '{1,  7,  0,  0,  7,  0,  0, 1, 1, 0, 0, C_BRANCH};
    vecs[6] = '{0,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, C_IDLE};
    vecs[7] = '{7,  0,  0,  0,  7,  0,  0, 0, 0, 0, 0, C_IDLE};
    vecs[8] = '{0,  0,  0,  0,  0,  0,  0, 0, 1, 0, 0, C_BRANCH};
    vecs[9] = '{12, 4, 12,  0, 12, 12,  0, 1, 0, 1, 0, 10'b1100011000};

    set_idle();

    // Reset release: exactly RFC flush cycles, then quiet.
    do_reset("init");
    for (int i = 0; i < RFC; i++) begin
      step("init");
      chk($sformatf("init.cyc%0d", i), last_ctl, C_INIT);
    end
    step("init_run");
    chk("init.after", last_ctl, C_IDLE);
    chk("init.stallcnt", last_sc, 0);

    // Vector table in RUN.
    for (int i = 0; i < 10; i++) begin
      {RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW} =
        {vecs[i].rs1d, vecs[i].rs2d, vecs[i].rs1e, vecs[i].rs2e, vecs[i].rde, vecs[i].rdm, vecs[i].rdw};
      {ResultSrcE, PCSrcE, RegWriteM, RegWriteW} = {vecs[i].lde, vecs[i].pcs, vecs[i].rwm, vecs[i].rww};
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.table", i), last_ctl, vecs[i].exp);
    end
    set_idle();

    // Load-use then load-use with branch: one stall, then one flush.
    do_reset("lu");
    repeat (RFC) step("lu_init");
    ResultSrcE = 1; RDE = 7; RS2D = 7;
    step("lu");
    chk("lu.ctl", last_ctl, C_LDUSE);
    PCSrcE = 1;
    step("lu_br");
    chk("lu_br.ctl", last_ctl, C_BRANCH);
    chk("lu_br.stallcnt", last_sc, 1);
    set_idle();
    step("lu_after");
    chk("lu.stallcnt", last_sc, 1);
    chk("lu.flushcnt", last_fc, 1);

    // Memory wait: three frozen cycles ignore the branch, then release in the ready cycle.
    do_reset("mw");
    repeat (RFC) step("mw_init");
    MemAccessM = 1; DmemReadyM = 0; PCSrcE = 1; ResultSrcE = 1; RDE = 3; RS1D = 3;
    for (int i = 0; i < 3; i++) begin
      step("mw");
      chk($sformatf("mw.frozen%0d", i), last_ctl, C_FREEZE);
    end
    DmemReadyM = 1; PCSrcE = 0; ResultSrcE = 0;
    step("mw_ready");
    chk("mw.ready", last_ctl, C_IDLE);
    set_idle();
    step("mw_after");
    chk("mw.stallcnt", last_sc, 3);
    chk("mw.flushcnt", last_fc, 0);
    chk("mw.memerr", last_err, 0);

    // Timeout: error appears after the 16th edge spent in MEM_WAIT, stays frozen and sticky.
    do_reset("to");
    repeat (RFC) step("to_init");
    MemAccessM = 1; DmemReadyM = 0;
    for (int i = 0; i < MT + 4; i++) begin
      step("to");
      chk($sformatf("to.frozen%0d", i), last_ctl, C_FREEZE);
      if (i == MT)     chk("to.err_before", last_err, 0);
      if (i == MT + 1) chk("to.err_set", last_err, 1);
    end
    DmemReadyM = 1;
    step("to_ready");
    chk("to.ready_ctl", last_ctl, C_IDLE);
    set_idle();
    step("to_after");
    chk("to.sticky", last_err, 1);
    do_reset("to_clear");

    // Saturation of the 4-bit copy under 20 load-use stalls.
    repeat (RFC) step("sat_init");
    ResultSrcE = 1; RDE = 9; RS1D = 9;
    repeat (20) step("sat");
    set_idle();
    step("sat_after");
    chk("sat.stallcnt4", last_ssc, 15);
    chk("sat.stallcnt32", last_sc, 20);

    // Randomized traffic with occasional reset mid-operation.
    do_reset("rnd");
    for (int i = 0; i < 3000; i++) begin
      RS1D = 5'($urandom_range(0, 3)); RS2D = 5'($urandom_range(0, 3));
      RS1E = 5'($urandom_range(0, 3)); RS2E = 5'($urandom_range(0, 3));
      RDE  = 5'($urandom_range(0, 3)); RDM  = 5'($urandom_range(0, 3));
      RDW  = 5'($urandom_range(0, 3));
      ResultSrcE = 1'($urandom_range(0, 1)); PCSrcE = ($urandom_range(0, 3) == 0);
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      MemAccessM = ($urandom_range(0, 2) != 0);
      if ((i / 100) % 2 == 1) DmemReadyM = ($urandom_range(0, 24) == 0);
      else                    DmemReadyM = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) do_reset("rnd");
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
